// File: rtl/hamming_secded_decoder.sv
// Serial extended-Hamming (16,11) SECDED receiver: deserialises code blocks into a
// hold register, then decodes them one cycle later while the next block streams in.
module hamming_secded_decoder #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             din,
  input  logic             din_valid,
  input  logic             sof,
  output logic [10:0]      dout,
  output logic             dout_valid,
  output logic [3:0]       syndrome,
  output logic             err_corrected,
  output logic             err_double,
  output logic [CNT_W-1:0] cnt_corr,
  output logic [CNT_W-1:0] cnt_dbl
);

  logic [3:0]       bcnt_q, bcnt_d;
  logic [15:0]      shift_q, shift_d;
  logic [15:0]      hold_q, hold_d;
  logic             pend_q, pend_d;
  logic [10:0]      dout_q;
  logic             vld_q;
  logic [3:0]       syn_q;
  logic             corr_q, dbl_q;
  logic [CNT_W-1:0] cnt_corr_q, cnt_dbl_q;

  // Capture: pending is a one-cycle flag unless a new block completes on this edge.
  always_comb begin
    bcnt_d  = bcnt_q;
    shift_d = shift_q;
    hold_d  = hold_q;
    pend_d  = 1'b0;
    if (din_valid) begin
      if (sof) begin
        shift_d[0] = din;
        bcnt_d     = 4'd1;
      end else begin
        shift_d[bcnt_q] = din;
        bcnt_d          = bcnt_q + 4'd1;
        if (bcnt_q == 4'd15) begin
          hold_d = shift_d;
          pend_d = 1'b1;
        end
      end
    end
  end

  logic [3:0]  syn_c;
  logic        par_c;
  logic [15:0] fixed_c;
  logic [10:0] data_c;

  always_comb begin
    syn_c = '0;
    for (int i = 0; i < 16; i++)
      if (hold_q[i]) syn_c = syn_c ^ 4'(i);
    par_c   = ^hold_q;
    fixed_c = hold_q;
    // Odd overall parity means exactly one flip; syndrome 0 points at the parity bit itself.
    if (par_c) fixed_c[syn_c] = ~hold_q[syn_c];
    data_c  = {fixed_c[15:9], fixed_c[7:5], fixed_c[3]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcnt_q     <= '0;
      shift_q    <= '0;
      hold_q     <= '0;
      pend_q     <= 1'b0;
      dout_q     <= '0;
      vld_q      <= 1'b0;
      syn_q      <= '0;
      corr_q     <= 1'b0;
      dbl_q      <= 1'b0;
      cnt_corr_q <= '0;
      cnt_dbl_q  <= '0;
    end else begin
      bcnt_q  <= bcnt_d;
      shift_q <= shift_d;
      hold_q  <= hold_d;
      pend_q  <= pend_d;
      vld_q   <= pend_q;
      if (pend_q) begin
        dout_q <= data_c;
        syn_q  <= syn_c;
        corr_q <= par_c;
        dbl_q  <= !par_c && (syn_c != 4'd0);
        if (par_c && (cnt_corr_q != '1))
          cnt_corr_q <= cnt_corr_q + CNT_W'(1);
        if (!par_c && (syn_c != 4'd0) && (cnt_dbl_q != '1))
          cnt_dbl_q <= cnt_dbl_q + CNT_W'(1);
      end
    end
  end

  assign dout          = dout_q;
  assign dout_valid    = vld_q;
  assign syndrome      = syn_q;
  assign err_corrected = corr_q;
  assign err_double    = dbl_q;
  assign cnt_corr      = cnt_corr_q;
  assign cnt_dbl       = cnt_dbl_q;

endmodule

// File: tb/tb_hamming_secded_decoder.sv
// Randomised bench for hamming_secded_decoder: encodes data, injects known errors and
// predicts the decoder response from the injected error set.
module tb_hamming_secded_decoder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        din = 1'b0, din_valid = 1'b0, sof = 1'b0;
  logic [10:0] dout;
  logic        dout_valid;
  logic [3:0]  syndrome;
  logic        err_corrected, err_double;
  logic [7:0]  cnt_corr, cnt_dbl;

  hamming_secded_decoder #(.CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .sof(sof),
    .dout(dout), .dout_valid(dout_valid), .syndrome(syndrome),
    .err_corrected(err_corrected), .err_double(err_double),
    .cnt_corr(cnt_corr), .cnt_dbl(cnt_dbl)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [10:0] dout;
    logic [3:0]  syn;
    logic        corr;
    logic        dbl;
    logic [7:0]  cc;
    logic [7:0]  cd;
  } rec_t;

  int   checks = 0;
  int   errors = 0;
  rec_t q[$];
  rec_t eq[$];
  int   mcc = 0, mcd = 0;

  always @(negedge clk)
    if (rst_n && dout_valid)
      q.push_back('{dout, syndrome, err_corrected, err_double, cnt_corr, cnt_dbl});

  function automatic bit is_par(int i);
    return (i & (i - 1)) == 0;
  endfunction

  function automatic logic [15:0] enc(input logic [10:0] d);
    logic [15:0] w;
    int j;
    w = '0; j = 0;
    for (int i = 1; i < 16; i++)
      if (!is_par(i)) begin w[i] = d[j]; j++; end
    for (int k = 1; k < 16; k = k * 2)
      for (int i = 1; i < 16; i++)
        if ((i & k) != 0 && i != k) w[k] = w[k] ^ w[i];
    w[0] = ^w[15:1];
    return w;
  endfunction

  function automatic logic [10:0] ext(input logic [15:0] w);
    logic [10:0] d;
    int j;
    d = '0; j = 0;
    for (int i = 1; i < 16; i++)
      if (!is_par(i)) begin d[j] = w[i]; j++; end
    return d;
  endfunction

  // Expected result follows from what was injected, not from recomputing the syndrome.
  task automatic model(input logic [15:0] clean, input int n, input int e1, input int e2,
                       output rec_t e, output logic [15:0] sent);
    sent = clean;
    if (n >= 1) sent[e1] = ~sent[e1];
    if (n == 2) sent[e2] = ~sent[e2];
    e = '0;
    if (n == 0) e.dout = ext(clean);
    else if (n == 1) begin
      e.dout = ext(clean); e.syn = 4'(e1); e.corr = 1'b1;
      if (mcc < 255) mcc++;
    end else begin
      e.dout = ext(sent); e.syn = 4'(e1 ^ e2); e.dbl = 1'b1;
      if (mcd < 255) mcd++;
    end
    e.cc = 8'(mcc);
    e.cd = 8'(mcd);
  endtask

  task automatic send_bit(input logic b, input logic s, input int maxgap);
    int g;
    g = (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0;
    repeat (g) begin @(posedge clk); #1; end
    din = b; sof = s; din_valid = 1'b1;
    @(posedge clk); #1;
    din_valid = 1'b0; sof = 1'b0;
  endtask

  task automatic send_block(input logic [15:0] w, input int maxgap);
    for (int i = 0; i < 16; i++) send_bit(w[i], i == 0, maxgap);
  endtask

  task automatic wait_q(input int n, input int budget);
    for (int k = 0; k < budget && q.size() < n; k++) begin @(posedge clk); #1; end
  endtask

  task automatic test_reset;
    if (dout !== 11'h000) begin errors++; $display("FAIL reset_dout: got %h want 000", dout); end
    checks++;
    if (dout_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", dout_valid); end
    checks++;
    if (syndrome !== 4'h0) begin errors++; $display("FAIL reset_syn: got %h want 0", syndrome); end
    checks++;
    if ({err_corrected, err_double} !== 2'b00) begin
      errors++; $display("FAIL reset_flags: got %b%b want 00", err_corrected, err_double);
    end
    checks++;
    if ({cnt_corr, cnt_dbl} !== 16'h0) begin
      errors++; $display("FAIL reset_cnt: got %0d/%0d want 0/0", cnt_corr, cnt_dbl);
    end
    checks++;
  endtask

  task automatic test_directed;
    logic [15:0] cl[5];
    int          n[5], a[5], b[5];
    rec_t        e, r;
    logic [15:0] w;
    cl = '{16'h0000, 16'hFFFF, 16'hFFFF, 16'h0000, 16'h0000};
    n  = '{0, 0, 1, 1, 2};
    a  = '{0, 0, 5, 0, 3};
    b  = '{0, 0, 0, 0, 5};
    for (int t = 0; t < 5; t++) begin
      model(cl[t], n[t], a[t], b[t], e, w);
      send_block(w, 0);
      wait_q(1, 6);
      repeat (3) begin @(posedge clk); #1; end
      if (q.size() != 1) begin
        errors++; $display("FAIL directed%0d_strobes: got %0d want 1", t + 1, q.size());
      end
      checks++;
      if (q.size() > 0) begin
        r = q.pop_front();
        if (r !== e) begin
          errors++;
          $display("FAIL directed%0d: got dout=%h syn=%h c=%b d=%b cc=%0d cd=%0d want dout=%h syn=%h c=%b d=%b cc=%0d cd=%0d",
                   t + 1, r.dout, r.syn, r.corr, r.dbl, r.cc, r.cd, e.dout, e.syn, e.corr, e.dbl, e.cc, e.cd);
        end
        checks++;
      end
      q.delete();
    end
  endtask

  task automatic test_random;
    rec_t        e, r;
    logic [15:0] w;
    int          nn, e1, e2;
    for (int t = 0; t < 40; t++) begin
      nn = $urandom_range(0, 2);
      e1 = $urandom_range(0, 15);
      e2 = (e1 + int'($urandom_range(1, 15))) % 16;
      model(enc(11'($urandom)), nn, e1, e2, e, w);
      send_block(w, 3);
      wait_q(1, 6);
      if (q.size() == 0) begin
        errors++; $display("FAIL random%0d_timeout: got 0 strobes want 1", t);
      end else begin
        r = q.pop_front();
        if (r !== e) begin
          errors++;
          $display("FAIL random%0d: got dout=%h syn=%h c=%b d=%b want dout=%h syn=%h c=%b d=%b",
                   t, r.dout, r.syn, r.corr, r.dbl, e.dout, e.syn, e.corr, e.dbl);
        end
      end
      checks++;
    end
  endtask

  task automatic test_back_to_back;
    rec_t        e, r;
    logic [15:0] w;
    int          nn;
    for (int t = 0; t < 8; t++) begin
      nn = $urandom_range(0, 1);
      model(enc(11'($urandom)), nn, int'($urandom_range(0, 15)), 0, e, w);
      eq.push_back(e);
      send_block(w, 0);
    end
    wait_q(8, 8);
    repeat (3) begin @(posedge clk); #1; end
    if (q.size() != 8) begin
      errors++; $display("FAIL b2b_strobes: got %0d want 8", q.size());
    end
    checks++;
    while (q.size() > 0 && eq.size() > 0) begin
      r = q.pop_front(); e = eq.pop_front();
      if (r !== e) begin
        errors++; $display("FAIL b2b_data: got dout=%h syn=%h want dout=%h syn=%h", r.dout, r.syn, e.dout, e.syn);
      end
      checks++;
    end
    q.delete(); eq.delete();
  endtask

  task automatic test_realign;
    rec_t        e, r;
    logic [15:0] w;
    for (int i = 0; i < 7; i++) send_bit(1'($urandom), i == 0, 1);
    model(enc(11'($urandom)), 1, int'($urandom_range(0, 15)), 0, e, w);
    send_block(w, 1);
    wait_q(1, 6);
    repeat (20) begin @(posedge clk); #1; end
    if (q.size() != 1) begin
      errors++; $display("FAIL realign_strobes: got %0d want 1", q.size());
    end
    checks++;
    if (q.size() > 0) begin
      r = q.pop_front();
      if (r !== e) begin
        errors++; $display("FAIL realign_data: got dout=%h syn=%h want dout=%h syn=%h", r.dout, r.syn, e.dout, e.syn);
      end
      checks++;
    end
    q.delete();
  endtask

  task automatic test_reset_mid;
    rec_t        e, r;
    logic [15:0] w;
    for (int i = 0; i < 10; i++) send_bit(1'($urandom), i == 0, 0);
    rst_n = 1'b0; #1;
    if ({dout, dout_valid, syndrome, err_corrected, err_double, cnt_corr, cnt_dbl} !== '0) begin
      errors++; $display("FAIL rstmid_outputs: got dout=%h syn=%h cc=%0d cd=%0d want all 0", dout, syndrome, cnt_corr, cnt_dbl);
    end
    checks++;
    @(posedge clk); #1; rst_n = 1'b1; mcc = 0; mcd = 0;
    // Full block, then reset while its decode is still pending.
    model(enc(11'h5A5), 1, 7, 0, e, w);
    mcc = 0;
    send_block(w, 0);
    rst_n = 1'b0; #1;
    if (dout_valid !== 1'b0) begin errors++; $display("FAIL rstmid_pend_valid: got %b want 0", dout_valid); end
    checks++;
    @(posedge clk); #1; rst_n = 1'b1;
    repeat (6) begin @(posedge clk); #1; end
    if (q.size() != 0) begin errors++; $display("FAIL rstmid_no_strobe: got %0d want 0", q.size()); end
    checks++;
    q.delete();
    model(enc(11'h3C3), 2, 2, 9, e, w);
    send_block(w, 0);
    wait_q(1, 6);
    if (q.size() == 0) begin
      errors++; $display("FAIL rstmid_after_timeout: got 0 strobes want 1");
    end else begin
      r = q.pop_front();
      if (r !== e) begin
        errors++; $display("FAIL rstmid_after: got dout=%h syn=%h d=%b cd=%0d want dout=%h syn=%h d=%b cd=%0d",
                           r.dout, r.syn, r.dbl, r.cd, e.dout, e.syn, e.dbl, e.cd);
      end
    end
    checks++;
    q.delete();
  endtask

  task automatic test_saturation;
    rec_t        e, r;
    logic [15:0] w;
    int          bad;
    bad = 0;
    for (int t = 0; t < 300; t++) begin
      model(enc(11'($urandom)), 1, int'($urandom_range(0, 15)), 0, e, w);
      eq.push_back(e);
      send_block(w, 0);
    end
    wait_q(300, 8);
    if (q.size() != 300) begin
      errors++; $display("FAIL sat_strobes: got %0d want 300", q.size());
    end
    checks++;
    while (q.size() > 0 && eq.size() > 0) begin
      r = q.pop_front(); e = eq.pop_front();
      if (r !== e) bad++;
    end
    if (bad != 0) begin errors++; $display("FAIL sat_blocks: got %0d bad blocks want 0", bad); end
    checks++;
    if (cnt_corr !== 8'd255) begin errors++; $display("FAIL sat_cnt_corr: got %0d want 255", cnt_corr); end
    checks++;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    rst_n = 1'b1;
    @(posedge clk); #1;
    test_directed();
    test_random();
    test_back_to_back();
    test_realign();
    test_reset_mid();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
